// File: rtl/ising_pkg.sv
// Shared types and constants for the Ising run sequencer.
package ising_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_SAMPLE = 2'd3
  } run_state_e;

  localparam int                     ISING_WBITS  = 3;
  localparam logic [ISING_WBITS-1:0] ISING_W_ZERO = 3'b010;

endpackage

// File: rtl/ising_phase_vote.sv
// Per-oscillator phase vote: 2-flop synchronizer plus a mismatch counter against the
// synchronized reference oscillator. vote reflects the count including the current cycle.
module ising_phase_vote
  import ising_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  input  logic ref_bit,  // "ref" is a reserved word
  input  logic in,
  output logic vote
);

  localparam int             VW   = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [VW-1:0]  HALF = VW'(SAMPLE_CYCLES / 2);

  logic          sync_p0, sync_p1;
  logic [VW-1:0] cnt, cnt_nxt;

  // Stage p0/p1: metastability synchronizer for the raw oscillator output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (en && (sync_p1 != ref_bit))
      cnt_nxt = cnt + VW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  // Looks at the next count so the final window cycle is included at the closing edge
  assign vote = (cnt_nxt > HALF);

endmodule

// File: rtl/ising_run_ctrl.sv
// Anneal sequencer for the coupled-oscillator Ising array: weight matrix, hold/run/sample FSM.
// Optional macro ISING_SYMMETRIC_WRITE_EN mirrors each accepted write to (col,row).
module ising_run_ctrl
  import ising_pkg::*;
#(
  parameter int N             = 3,
  parameter int WBITS         = 3,
  parameter int CNT_W         = 16,
  parameter int SAMPLE_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 cfg_we,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] cfg_row,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] cfg_col,
  input  logic [WBITS-1:0]                     cfg_wdata,
  output logic                                 cfg_err,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [CNT_W-1:0]                     hold_cycles,
  input  logic [CNT_W-1:0]                     run_cycles,
  output logic                                 osc_rstn,
  output logic [N*N*WBITS-1:0]                 coupling_weights,
  input  logic [N-1:0]                         osc_out,
  output logic                                 busy,
  output logic                                 done,
  output logic [N-1:0]                         spins
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);
  localparam int CW = (CNT_W > SW) ? CNT_W : SW;

  run_state_e       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] run_lat;
  logic             done_nxt;
  logic             wr_ok;
  logic             osc0_p0, osc0_p1;
  logic [N-1:0]     vote;
  logic [WBITS-1:0] w [N][N];

  function automatic logic [CNT_W-1:0] hold_min1(input logic [CNT_W-1:0] h);
    return (h == '0) ? CNT_W'(1) : h;
  endfunction

  assign wr_ok = cfg_we && (state == ST_IDLE) &&
                 ({1'b0, cfg_row} < (RW + 1)'(N)) &&
                 ({1'b0, cfg_col} < (RW + 1)'(N));

  // Down counter reloaded at each phase entry; phase ends when it reads 1
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CW'(hold_min1(hold_cycles));
        end
      end
      ST_HOLD: begin
        if (cnt == CW'(1)) begin
          if (run_lat == '0) begin
            state_nxt = ST_SAMPLE;
            cnt_nxt   = CW'(SAMPLE_CYCLES);
          end else begin
            state_nxt = ST_RUN;
            cnt_nxt   = CW'(run_lat);
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_RUN: begin
        if (cnt == CW'(1)) begin
          state_nxt = ST_SAMPLE;
          cnt_nxt   = CW'(SAMPLE_CYCLES);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_SAMPLE: begin
        if (cnt == CW'(1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      run_lat  <= '0;
      osc_rstn <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      spins    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      osc_rstn <= (state_nxt == ST_RUN) || (state_nxt == ST_SAMPLE);
      busy     <= (state_nxt != ST_IDLE);
      done     <= done_nxt;
      cfg_err  <= cfg_we && !wr_ok;
      if ((state == ST_IDLE) && start) run_lat <= run_cycles;
      if (done_nxt)                    spins   <= vote;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w[i][j] <= WBITS'(ISING_W_ZERO);
    end else if (wr_ok) begin
      w[cfg_row][cfg_col] <= cfg_wdata;
`ifdef ISING_SYMMETRIC_WRITE_EN
      w[cfg_col][cfg_row] <= cfg_wdata;
`endif
    end
  end

  always_comb begin
    coupling_weights = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        coupling_weights[i*N*WBITS + j*WBITS +: WBITS] = w[i][j];
  end

  // Stage p0/p1: reference oscillator synchronizer, aligned with the per-spin ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      osc0_p0 <= 1'b0;
      osc0_p1 <= 1'b0;
    end else begin
      osc0_p0 <= osc_out[0];
      osc0_p1 <= osc0_p0;
    end
  end

  assign vote[0] = 1'b0;

  for (genvar gi = 1; gi < N; gi++) begin : g_vote
    ising_phase_vote #(
      .SAMPLE_CYCLES(SAMPLE_CYCLES)
    ) u_vote (
      .clk    (clk),
      .rstn   (rstn),
      .clr    ((state == ST_IDLE) || abort),
      .en     (state == ST_SAMPLE),
      .ref_bit(osc0_p1),
      .in     (osc_out[gi]),
      .vote   (vote[gi])
    );
  end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: table-driven weight writes plus run, abort and reset sequences.
module tb_ising_run_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_we;
  logic [1:0]  cfg_row, cfg_col;
  logic [2:0]  cfg_wdata;
  logic        cfg_err;
  logic        start, abort;
  logic [15:0] hold_cycles, run_cycles;
  logic        osc_rstn;
  logic [26:0] coupling_weights;
  logic [2:0]  osc_out;
  logic        busy, done;
  logic [2:0]  spins;

  int n_chk  = 0;
  int n_pass = 0;
  int osc_mode = 0;

  logic [2:0] mw [3][3];

  typedef struct {
    logic       we;
    logic [1:0] row;
    logic [1:0] col;
    logic [2:0] wdata;
    logic       exp_err;
  } wr_vec_t;

  wr_vec_t vecs [6];

  ising_run_ctrl #(.N(3), .WBITS(3), .CNT_W(16), .SAMPLE_CYCLES(64)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .cfg_we          (cfg_we),
    .cfg_row         (cfg_row),
    .cfg_col         (cfg_col),
    .cfg_wdata       (cfg_wdata),
    .cfg_err         (cfg_err),
    .start           (start),
    .abort           (abort),
    .hold_cycles     (hold_cycles),
    .run_cycles      (run_cycles),
    .osc_rstn        (osc_rstn),
    .coupling_weights(coupling_weights),
    .osc_out         (osc_out),
    .busy            (busy),
    .done            (done),
    .spins           (spins)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [26:0] flat_model();
    logic [26:0] f;
    f = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        f[i*9 + j*3 +: 3] = mw[i][j];
    return f;
  endfunction

  // osc0 toggles every 3 cycles; osc_mode picks how osc1/osc2 relate to it
  initial begin
    logic o0;
    int   ph;
    o0 = 1'b0;
    ph = 0;
    osc_out = 3'b000;
    forever begin
      @(posedge clk);
      #2;
      ph = (ph == 2) ? 0 : ph + 1;
      if (ph == 0) o0 = ~o0;
      case (osc_mode)
        1:       osc_out = {o0, ~o0, o0};
        2:       osc_out = {~o0, o0, o0};
        default: osc_out = {o0, o0, o0};
      endcase
    end
  end

  task automatic run_measure(input string tag, input int h, input int r,
                             input int exp_low, input int exp_high, input logic [2:0] exp_spins);
    int lo, hi, early;
    lo = 0; hi = 0; early = 0;
    hold_cycles = 16'(h);
    run_cycles  = 16'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    while (osc_rstn === 1'b0 && lo < 70000) begin
      if (done) early++;
      lo++;
      tick();
    end
    chk({tag, "_low_len"}, lo, exp_low);
    while (osc_rstn === 1'b1 && hi < 70000) begin
      if (done) early++;
      hi++;
      tick();
    end
    chk({tag, "_high_len"}, hi, exp_high);
    chk({tag, "_no_early_done"}, early, 0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_spins"}, 32'(spins), 32'(exp_spins));
    tick();
    chk({tag, "_done_one_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen_done;
    rstn = 1'b0;
    cfg_we = 1'b0; cfg_row = '0; cfg_col = '0; cfg_wdata = '0;
    start = 1'b0; abort = 1'b0; hold_cycles = '0; run_cycles = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        mw[i][j] = 3'b010;

    vecs[0] = '{1'b1, 2'd1, 2'd0, 3'b100, 1'b0};
    vecs[1] = '{1'b1, 2'd3, 2'd0, 3'b011, 1'b1};
    vecs[2] = '{1'b1, 2'd0, 2'd3, 3'b101, 1'b1};
    vecs[3] = '{1'b1, 2'd2, 2'd2, 3'b111, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 2'd2, 3'b001, 1'b0};
    vecs[5] = '{1'b0, 2'd1, 2'd1, 3'b110, 1'b0};

    #23;
    chk("rst_weights",  32'(coupling_weights), 32'(flat_model()));
    chk("rst_osc_rstn", 32'(osc_rstn), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_cfg_err",  32'(cfg_err),  32'd0);
    chk("rst_spins",    32'(spins),    32'd0);
    rstn = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 6; i++) begin
      cfg_we = vecs[i].we; cfg_row = vecs[i].row; cfg_col = vecs[i].col; cfg_wdata = vecs[i].wdata;
      if (vecs[i].we && vecs[i].row < 2'd3 && vecs[i].col < 2'd3) begin
        mw[vecs[i].row][vecs[i].col] = vecs[i].wdata;
`ifdef ISING_SYMMETRIC_WRITE_EN
        mw[vecs[i].col][vecs[i].row] = vecs[i].wdata;
`endif
      end
      tick();
      cfg_we = 1'b0;
      chk($sformatf("wr%0d_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
      chk($sformatf("wr%0d_weights", i), 32'(coupling_weights), 32'(flat_model()));
      if (i == 0) begin
        chk("wr0_bits_11_9", 32'(coupling_weights[11:9]), 32'd4);
`ifdef ISING_SYMMETRIC_WRITE_EN
        chk("wr0_bits_5_3", 32'(coupling_weights[5:3]), 32'd4);
`else
        chk("wr0_bits_5_3", 32'(coupling_weights[5:3]), 32'd2);
`endif
      end
      tick();
      chk($sformatf("wr%0d_err_clear", i), 32'(cfg_err), 32'd0);
    end

    // Write and start in the same cycle: write must land
    cfg_we = 1'b1; cfg_row = 2'd2; cfg_col = 2'd1; cfg_wdata = 3'b110;
    mw[2][1] = 3'b110;
`ifdef ISING_SYMMETRIC_WRITE_EN
    mw[1][2] = 3'b110;
`endif
    osc_mode = 1;
    hold_cycles = 16'd100;
    run_cycles  = 16'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    chk("wr_start_weights", 32'(coupling_weights), 32'(flat_model()));
    chk("wr_start_busy", 32'(busy), 32'd1);
    // Let that run finish, then do the measured run
    repeat (1200) begin
      if (!busy) break;
      tick();
    end
    tick();
    chk("first_run_idle", 32'(busy), 32'd0);

    run_measure("run_h100_r1000", 100, 1000, 100, 1064, 3'b010);

    // Abort during RUN, with a rejected write while busy
    hold_cycles = 16'd100;
    run_cycles  = 16'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    chk("abort_in_run", 32'(osc_rstn), 32'd1);
    cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd0; cfg_wdata = 3'b111;
    tick();
    cfg_we = 1'b0;
    chk("busy_wr_err", 32'(cfg_err), 32'd1);
    chk("busy_wr_weights", 32'(coupling_weights), 32'(flat_model()));
    tick();
    chk("busy_wr_err_clear", 32'(cfg_err), 32'd0);
    repeat (497) tick();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_osc_rstn", 32'(osc_rstn), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    seen_done = 0;
    repeat (600) begin
      if (done) seen_done++;
      tick();
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_spins_kept", 32'(spins), 32'd2);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    osc_mode = 2;
    run_measure("run_h0_r0", 0, 0, 1, 64, 3'b100);

    osc_mode = 0;
    run_measure("run_h3_r5_match", 3, 5, 3, 69, 3'b000);

    // Asynchronous reset mid-run
    hold_cycles = 16'd2;
    run_cycles  = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        mw[i][j] = 3'b010;
    chk("mid_rst_weights",  32'(coupling_weights), 32'(flat_model()));
    chk("mid_rst_osc_rstn", 32'(osc_rstn), 32'd0);
    chk("mid_rst_busy",     32'(busy),     32'd0);
    chk("mid_rst_spins",    32'(spins),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ising_run_ctrl.md
# ising_run_ctrl

Run sequencer for the coupled-oscillator Ising array. Holds the N×N coupling-weight matrix that drives each oscillator's `coupling_weights` bus and sequences one anneal: reset hold, free run, then a phase-sampling window. The window votes each oscillator's phase against oscillator 0 and reports the spin vector. Sits between the host/config logic and the oscillator array; the array's `rstn` is driven only from this block.

## Interface
- `N`, 3: number of oscillators/spins.
- `WBITS`, 3: coupling-weight width; offset encoding, 3'b010 = zero coupling.
- `CNT_W`, 16: width of the hold/run cycle counters.
- `SAMPLE_CYCLES`, 64: length of the phase-vote window, ≥2.

- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  weight write strobe.
- `cfg_row`  in  $clog2(N)  destination oscillator i.
- `cfg_col`  in  $clog2(N)  source oscillator j.
- `cfg_wdata`  in  WBITS  weight value.
- `cfg_err`  out  1  one-cycle pulse for a rejected write.
- `start`  in  1  begin a run; accepted only in IDLE.
- `abort`  in  1  cancel a run in progress.
- `hold_cycles`  in  CNT_W  reset-hold length; sampled on accepted `start`.
- `run_cycles`  in  CNT_W  free-run length; sampled on accepted `start`.
- `osc_rstn`  out  1  reset to every oscillator.
- `coupling_weights`  out  N*N*WBITS  oscillator i slice at `[i*N*WBITS +: N*WBITS]`; weight from j at `[j*WBITS +: WBITS]` within that slice.
- `osc_out`  in  N  raw oscillator outputs; asynchronous to `clk`.
- `busy`  out  1  high in HOLD/RUN/SAMPLE.
- `done`  out  1  one-cycle pulse at run completion.
- `spins`  out  N  spin result; bit 0 is always 0.

## Operation
- States are IDLE, HOLD, RUN and SAMPLE.
- IDLE + `start` → HOLD. Latch `max(hold_cycles,1)` and `run_cycles`.
- HOLD drives `osc_rstn`=0. After the latched hold count: → RUN, or → SAMPLE if `run_cycles`=0.
- RUN drives `osc_rstn`=1 for `run_cycles` cycles, then → SAMPLE.
- SAMPLE keeps `osc_rstn`=1 for SAMPLE_CYCLES cycles, then → IDLE.
- On the SAMPLE → IDLE transition: pulse `done` and update `spins`.
- IDLE drives `osc_rstn`=0.
- `osc_out` passes through a 2-flop synchronizer per bit.
- SAMPLE: per oscillator i≥1, count the cycles where `sync[i] != sync[0]`.
- `spins[i]` = count > SAMPLE_CYCLES/2 (strict). A tie gives 0.
- `spins` holds its value until the next `done`.
- Weight write is accepted only when all of these hold: IDLE, `cfg_row`<N, `cfg_col`<N.
  - An accepted write updates the matrix at the same edge.
  - Otherwise nothing is written, and `cfg_err` pulses on the next cycle.
- `cfg_we` and `start` in the same IDLE cycle: the write lands, and the run uses the new weight.
- `abort` has priority in any non-IDLE state:
  - next cycle is IDLE, `osc_rstn`=0, `busy`=0;
  - no `done`; `spins` unchanged; vote counters cleared.
- `start` while busy is ignored. `abort` in IDLE has no effect.

## Timing
- Reset values:
  - state IDLE; `osc_rstn`=0;
  - `busy`=0, `done`=0, `cfg_err`=0, `spins`=0;
  - every weight = 3'b010.
- `start` accepted at edge k: `busy`=1 from k+1.
- `osc_rstn` is low for exactly H cycles starting at k+1, then high for exactly R+SAMPLE_CYCLES cycles.
- `done`=1 and `busy`=0 in the cycle after the last SAMPLE cycle.
- Counters do not wrap: `hold_cycles`/`run_cycles` = 2^CNT_W−1 is legal and exact.
- The first 2 SAMPLE cycles see run-phase data through the synchronizer. This is accepted and is not compensated.
- `rstn` asserted mid-run: all outputs take their reset values asynchronously, including the weights.

## Configuration
- `ISING_SYMMETRIC_WRITE_EN` defined: an accepted write to (r,c) also writes (c,r) at the same edge. The diagonal (r=c) is written once.
- Undefined: only (r,c) is written.

## Structure
- Package `ising_pkg`:
  - state enum;
  - `ISING_WBITS`=3;
  - `ISING_W_ZERO`=3'b010.
- Sub-module `ising_phase_vote`, one instance per oscillator i≥1:
  - holds the synchronizer and the mismatch counter;
  - ports: clr, en, ref, in, vote.

## Test plan
- Config: N=3, SAMPLE_CYCLES=64.
- Reset: `rstn`=0 → `coupling_weights`=27'b010 repeated ×9, `osc_rstn`=0, `busy`=0, `spins`=0.
- Write (row1, col0, 3'b100) in IDLE → bits [11:9]=100.
  - With the macro: bits [5:3]=100 as well.
  - Without the macro: bits [5:3] stay 010.
- `start` with hold=100, run=1000 → `osc_rstn` low for 100 cycles, then high for 1064 cycles. `done` pulses once; `busy` falls the same cycle.
- During SAMPLE, osc[0] toggles every 3 cycles, osc[1]=~osc[0], osc[2]=osc[0] → `spins`=3'b010.
- `abort` at RUN cycle 500 → IDLE next cycle, `osc_rstn`=0, no `done`, `spins` retains its prior value.
- Rejected writes and zero counts:
  - `cfg_we` while busy → one `cfg_err` pulse, weights unchanged;
  - `cfg_row`=3 → one `cfg_err` pulse, weights unchanged;
  - hold=0, run=0 → `osc_rstn` low 1 cycle, then SAMPLE immediately, `done` after 64 cycles.
